pong_draw_engine: RTL and testbench

- Rasterising draw engine between the game logic and the 160x120 VGA frame-buffer adapter.
- On each frame request it latches ball and paddle positions and erases the previous frame's objects in black.
- It then redraws the objects at the new positions, emitting one pixel write (x, y, colour, plot) per clock.
- Outputs connect directly to the adapter's x/y/colour/plot inputs (1 bit per colour channel).

---
 rtl/pong_draw_engine.sv | 212 +++++++++++++++++++++
 tb/tb_pong_draw_engine.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_draw_engine.sv
// Rasterising erase/redraw engine for ball and paddles feeding a 160x120 frame-buffer adapter.
// Optional centre-net repaint pass enabled by defining PONG_DRAW_NET_EN.
module pong_draw_engine #(
    parameter int unsigned BALL_SIZE  = 2,
    parameter int unsigned PADDLE_W   = 2,
    parameter int unsigned PADDLE_H   = 16,
    parameter int unsigned PADDLE_L_X = 4,
    parameter int unsigned PADDLE_R_X = 154,
    parameter logic [2:0]  OBJ_COLOUR = 3'b111
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_start,
    input  logic [7:0] ball_x,
    input  logic [6:0] ball_y,
    input  logic [6:0] paddle_l_y,
    input  logic [6:0] paddle_r_y,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int unsigned SCR_W = 160;
    localparam int unsigned SCR_H = 120;
    localparam int unsigned NET_X = 79;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ERASE_BALL,
        S_ERASE_PL,
        S_ERASE_PR,
        S_NET,
        S_DRAW_BALL,
        S_DRAW_PL,
        S_DRAW_PR,
        S_DONE
    } state_t;

`ifdef PONG_DRAW_NET_EN
    localparam state_t FIRST_DRAW = S_NET;
`else
    localparam state_t FIRST_DRAW = S_DRAW_BALL;
`endif

    state_t           state, state_n;
    logic [CNT_W-1:0] cx, cx_n, cy, cy_n;
    logic [CNT_W-1:0] last_cx, last_cy;
    state_t           after_scan;
    logic             accept;

    logic [7:0] cur_bx, prev_bx, cur_bx_n;
    logic [6:0] cur_by, prev_by, cur_by_n;
    logic [6:0] cur_pl, prev_pl, cur_pl_n;
    logic [6:0] cur_pr, prev_pr, cur_pr_n;
    logic       prev_valid;

    logic [7:0] ox;
    logic [6:0] oy;
    logic [2:0] col_n;
    logic       scan_n;
    logic [8:0] px;
    logic [7:0] py;
    logic       plot_n;

    // Scan extent and successor of the current scan state.
    always_comb begin
        last_cx    = '0;
        last_cy    = '0;
        after_scan = S_IDLE;
        case (state)
            S_ERASE_BALL: begin
                last_cx = CNT_W'(BALL_SIZE - 1);  last_cy = CNT_W'(BALL_SIZE - 1);
                after_scan = S_ERASE_PL;
            end
            S_ERASE_PL: begin
                last_cx = CNT_W'(PADDLE_W - 1);   last_cy = CNT_W'(PADDLE_H - 1);
                after_scan = S_ERASE_PR;
            end
            S_ERASE_PR: begin
                last_cx = CNT_W'(PADDLE_W - 1);   last_cy = CNT_W'(PADDLE_H - 1);
                after_scan = FIRST_DRAW;
            end
            S_NET: begin
                last_cx = '0;                     last_cy = CNT_W'(SCR_H - 1);
                after_scan = S_DRAW_BALL;
            end
            S_DRAW_BALL: begin
                last_cx = CNT_W'(BALL_SIZE - 1);  last_cy = CNT_W'(BALL_SIZE - 1);
                after_scan = S_DRAW_PL;
            end
            S_DRAW_PL: begin
                last_cx = CNT_W'(PADDLE_W - 1);   last_cy = CNT_W'(PADDLE_H - 1);
                after_scan = S_DRAW_PR;
            end
            S_DRAW_PR: begin
                last_cx = CNT_W'(PADDLE_W - 1);   last_cy = CNT_W'(PADDLE_H - 1);
                after_scan = S_DONE;
            end
            default: ;
        endcase
    end

    // Next state and scan counters.
    always_comb begin
        state_n = state;
        cx_n    = cx;
        cy_n    = cy;
        accept  = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_start) begin
                    accept  = 1'b1;
                    state_n = prev_valid ? S_ERASE_BALL : FIRST_DRAW;
                    cx_n    = '0;
                    cy_n    = '0;
                end
            end
            S_DONE: state_n = S_IDLE;
            default: begin
                if (cx == last_cx) begin
                    cx_n = '0;
                    if (cy == last_cy) begin
                        cy_n    = '0;
                        state_n = after_scan;
                    end else begin
                        cy_n = cy + CNT_W'(1);
                    end
                end else begin
                    cx_n = cx + CNT_W'(1);
                end
            end
        endcase
    end

    assign cur_bx_n = accept ? ball_x     : cur_bx;
    assign cur_by_n = accept ? ball_y     : cur_by;
    assign cur_pl_n = accept ? paddle_l_y : cur_pl;
    assign cur_pr_n = accept ? paddle_r_y : cur_pr;

    // Pixel for the upcoming cycle, so outputs line up with the registered state.
    always_comb begin
        ox     = '0;
        oy     = '0;
        col_n  = 3'b000;
        scan_n = 1'b1;
        case (state_n)
            S_ERASE_BALL: begin ox = prev_bx;             oy = prev_by;  end
            S_ERASE_PL:   begin ox = 8'(PADDLE_L_X);      oy = prev_pl;  end
            S_ERASE_PR:   begin ox = 8'(PADDLE_R_X);      oy = prev_pr;  end
            S_NET:        begin ox = 8'(NET_X);           col_n = 3'b111; end
            S_DRAW_BALL:  begin ox = cur_bx_n; oy = cur_by_n; col_n = OBJ_COLOUR; end
            S_DRAW_PL:    begin ox = 8'(PADDLE_L_X); oy = cur_pl_n; col_n = OBJ_COLOUR; end
            S_DRAW_PR:    begin ox = 8'(PADDLE_R_X); oy = cur_pr_n; col_n = OBJ_COLOUR; end
            default:      scan_n = 1'b0;
        endcase
        px     = 9'(ox) + 9'(cx_n);
        py     = 8'(oy) + cy_n;
        plot_n = scan_n && (px < 9'(SCR_W)) && (py < 8'(SCR_H));
        if (state_n == S_NET && cy_n[2]) begin
            plot_n = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cx         <= '0;
            cy         <= '0;
            cur_bx     <= '0;
            cur_by     <= '0;
            cur_pl     <= '0;
            cur_pr     <= '0;
            prev_bx    <= '0;
            prev_by    <= '0;
            prev_pl    <= '0;
            prev_pr    <= '0;
            prev_valid <= 1'b0;
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state  <= state_n;
            cx     <= cx_n;
            cy     <= cy_n;
            cur_bx <= cur_bx_n;
            cur_by <= cur_by_n;
            cur_pl <= cur_pl_n;
            cur_pr <= cur_pr_n;
            if (state == S_DONE) begin
                prev_bx    <= cur_bx;
                prev_by    <= cur_by;
                prev_pl    <= cur_pl;
                prev_pr    <= cur_pr;
                prev_valid <= 1'b1;
            end
            x      <= scan_n ? px[7:0] : 8'd0;
            y      <= scan_n ? py[6:0] : 7'd0;
            colour <= scan_n ? col_n : 3'b000;
            plot   <= plot_n;
            busy   <= (state_n != S_IDLE);
            done   <= (state_n == S_DONE);
        end
    end

endmodule

// File: tb/tb_pong_draw_engine.sv
// Bench for pong_draw_engine: per-cycle pixel-list model plus hand-computed frame checks.
// Honours PONG_DRAW_NET_EN for the net pass.
module tb_pong_draw_engine;

`ifdef PONG_DRAW_NET_EN
    localparam int NET_CYC   = 120;
    localparam int NET_PLOTS = 60;
`else
    localparam int NET_CYC   = 0;
    localparam int NET_PLOTS = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic [7:0] ball_x;
    logic [6:0] ball_y, paddle_l_y, paddle_r_y;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;

    pong_draw_engine dut (
        .clock(clk), .reset(reset), .frame_start(frame_start),
        .ball_x(ball_x), .ball_y(ball_y), .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] col;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic chk_en = 1'b0;

    // model state
    logic m_busy = 1'b0;
    logic m_prev_valid = 1'b0;
    int   m_prev[4];
    int   m_cur[4];

    // per-frame statistics from the DUT outputs
    int frame_cyc, plot_cnt, done_at, done_cnt, busy_fall_at, oob_cnt, net_cnt;
    int lx, ly, lc;
    int fx[4], fy[4], fc[4];

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_rect(input int ox, input int oy, input int w, input int h, input int c);
        for (int r = 0; r < h; r++) begin
            for (int cc = 0; cc < w; cc++) begin
                exp_t e;
                e.busy = 1'b1;
                e.done = 1'b0;
                e.plot = ((ox + cc) < 160) && ((oy + r) < 120);
                e.x    = 8'(ox + cc);
                e.y    = 7'(oy + r);
                e.col  = 3'(c);
                q.push_back(e);
            end
        end
    endtask

    // Model: on each accepted request, expand the frame into its full per-cycle pixel list.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_busy = 1'b0;
            m_prev_valid = 1'b0;
        end else if (frame_start && !m_busy) begin
            exp_t d;
            m_cur[0] = int'(ball_x);
            m_cur[1] = int'(ball_y);
            m_cur[2] = int'(paddle_l_y);
            m_cur[3] = int'(paddle_r_y);
            if (m_prev_valid) begin
                push_rect(m_prev[0], m_prev[1], 2, 2, 0);
                push_rect(4, m_prev[2], 2, 16, 0);
                push_rect(154, m_prev[3], 2, 16, 0);
            end
`ifdef PONG_DRAW_NET_EN
            for (int ny = 0; ny < 120; ny++) begin
                exp_t e;
                e.busy = 1'b1; e.done = 1'b0;
                e.plot = (ny % 8) < 4;
                e.x = 8'd79; e.y = 7'(ny); e.col = 3'b111;
                q.push_back(e);
            end
`endif
            push_rect(m_cur[0], m_cur[1], 2, 2, 7);
            push_rect(4, m_cur[2], 2, 16, 7);
            push_rect(154, m_cur[3], 2, 16, 7);
            d = '0;
            d.busy = 1'b1;
            d.done = 1'b1;
            q.push_back(d);
            m_busy = 1'b1;
            frame_cyc = 0; plot_cnt = 0; done_at = 0; done_cnt = 0;
            busy_fall_at = 0; oob_cnt = 0; net_cnt = 0;
        end
    end

    // Compare process: every cycle against the model, plus statistics collection.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_t e;
            e = '0;
            if (q.size() > 0) e = q.pop_front();
            cmp("busy", int'(busy), int'(e.busy));
            cmp("done", int'(done), int'(e.done));
            cmp("plot", int'(plot), int'(e.plot));
            if (e.plot) begin
                cmp("x", int'(x), int'(e.x));
                cmp("y", int'(y), int'(e.y));
                cmp("colour", int'(colour), int'(e.col));
            end
            if (e.done) begin
                m_prev = m_cur;
                m_prev_valid = 1'b1;
            end
            m_busy = e.busy;

            frame_cyc++;
            if (plot === 1'b1) begin
                if (plot_cnt < 4) begin
                    fx[plot_cnt] = int'(x); fy[plot_cnt] = int'(y); fc[plot_cnt] = int'(colour);
                end
                plot_cnt++;
                lx = int'(x); ly = int'(y); lc = int'(colour);
                if (x >= 8'd160 || y >= 7'd120) oob_cnt++;
                if (x == 8'd79) net_cnt++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = frame_cyc;
            end
            if (busy === 1'b0 && busy_fall_at == 0) busy_fall_at = frame_cyc;
        end
    end

    task automatic start_frame(input int bx, input int by, input int pl, input int pr);
        @(negedge clk);
        ball_x = 8'(bx); ball_y = 7'(by); paddle_l_y = 7'(pl); paddle_r_y = 7'(pr);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0;
        ball_x = '0; ball_y = '0; paddle_l_y = '0; paddle_r_y = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        cmp("reset_plot", int'(plot), 0);
        cmp("reset_busy", int'(busy), 0);
        cmp("reset_xy", int'(x) + int'(y) + int'(colour), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // first frame: draw only
        start_frame(10, 20, 30, 50);
        repeat (300) @(negedge clk);
        cmp("f1_plots", plot_cnt, 68 + NET_PLOTS);
        cmp("f1_done_at", done_at, 69 + NET_CYC);
        cmp("f1_busy_fall", busy_fall_at, 70 + NET_CYC);
        if (NET_CYC == 0) begin
            cmp("f1_first_x", fx[0], 10);
            cmp("f1_first_y", fy[0], 20);
            cmp("f1_first_c", fc[0], 7);
        end else begin
            cmp("f1_first_x", fx[0], 79);
            cmp("f1_first_y", fy[0], 0);
            cmp("f1_first_c", fc[0], 7);
        end

        // second frame: erase old ball first
        start_frame(12, 20, 30, 50);
        repeat (300) @(negedge clk);
        cmp("f2_e0_x", fx[0], 10); cmp("f2_e0_y", fy[0], 20);
        cmp("f2_e1_x", fx[1], 11); cmp("f2_e1_y", fy[1], 20);
        cmp("f2_e2_x", fx[2], 10); cmp("f2_e2_y", fy[2], 21);
        cmp("f2_e3_x", fx[3], 11); cmp("f2_e3_y", fy[3], 21);
        cmp("f2_e_col", fc[0] + fc[1] + fc[2] + fc[3], 0);
        cmp("f2_plots", plot_cnt, 136 + NET_PLOTS);
        cmp("f2_done_at", done_at, 137 + NET_CYC);
        cmp("f2_last_x", lx, 155);
        cmp("f2_last_y", ly, 65);
        cmp("f2_last_c", lc, 7);
        cmp("f2_net_plots", net_cnt, NET_PLOTS);

        // ball at the bottom-right corner: clipped
        start_frame(159, 119, 30, 50);
        repeat (300) @(negedge clk);
        cmp("f3_plots", plot_cnt, 133 + NET_PLOTS);
        cmp("f3_done_at", done_at, 137 + NET_CYC);
        cmp("f3_oob", oob_cnt, 0);

        // request and input changes mid-frame are ignored
        start_frame(40, 60, 10, 90);
        repeat (38) @(negedge clk);
        ball_x = 8'd100; ball_y = 7'd100; paddle_l_y = 7'd0; paddle_r_y = 7'd0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (300) @(negedge clk);
        cmp("f4_done_cnt", done_cnt, 1);
        cmp("f4_plots", plot_cnt, 133 + NET_PLOTS);

        // reset mid-frame, then a draw-only frame
        start_frame(70, 30, 40, 40);
        repeat (49) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cmp("rst_plot", int'(plot), 0);
        cmp("rst_busy", int'(busy), 0);
        repeat (5) @(negedge clk);
        cmp("rst_done_cnt", done_cnt, 0);
        start_frame(20, 40, 60, 70);
        repeat (300) @(negedge clk);
        cmp("f5_done_at", done_at, 69 + NET_CYC);
        cmp("f5_plots", plot_cnt, 68 + NET_PLOTS);
        cmp("f5_queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
